// File: rtl/azpr_bus_arbiter_pkg.sv
// Shared global definitions for the AZPR bus arbiter.
// Logic levels, active-low enables, reset polarity and owner codes.
package azpr_bus_arbiter_pkg;

   localparam logic HIGH          = 1'b1;
   localparam logic LOW           = 1'b0;

   localparam logic ENABLE_       = 1'b0;
   localparam logic DISABLE_      = 1'b1;

   localparam logic RESET_ENABLE  = 1'b1;
   localparam logic RESET_DISABLE = 1'b0;

   localparam int BUS_OWNER_BUS = 2;

   localparam logic [BUS_OWNER_BUS-1:0] BUS_OWNER_MASTER_0 = 2'd0;
   localparam logic [BUS_OWNER_BUS-1:0] BUS_OWNER_MASTER_1 = 2'd1;
   localparam logic [BUS_OWNER_BUS-1:0] BUS_OWNER_MASTER_2 = 2'd2;
   localparam logic [BUS_OWNER_BUS-1:0] BUS_OWNER_MASTER_3 = 2'd3;

endpackage

// File: rtl/bus_arb_next_owner.sv
// Next-owner selection for the AZPR bus arbiter (combinational).
// BUS_ARBITER_FIXED_PRIO_EN selects fixed m0>m1>m2>m3 handover.
module bus_arb_next_owner
   import azpr_bus_arbiter_pkg::*;
(
   input  logic [BUS_OWNER_BUS-1:0] owner_i,
   input  logic [3:0]               req_n_i,
   output logic [BUS_OWNER_BUS-1:0] next_owner_o
);

   logic                     found;
   logic [BUS_OWNER_BUS-1:0] cand;

   // Keep a requesting owner; otherwise hand over to the first requester.
   always_comb begin
      next_owner_o = owner_i;
      found        = 1'b0;
      cand         = owner_i;
      if (req_n_i[owner_i] == DISABLE_) begin
`ifdef BUS_ARBITER_FIXED_PRIO_EN
         for (int i = 0; i < 4; i++) begin
            cand = BUS_OWNER_BUS'(i);
            if (!found && req_n_i[cand] == ENABLE_) begin
               next_owner_o = cand;
               found        = 1'b1;
            end
         end
`else
         for (int i = 1; i < 4; i++) begin
            cand = owner_i + BUS_OWNER_BUS'(i);
            if (!found && req_n_i[cand] == ENABLE_) begin
               next_owner_o = cand;
               found        = 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: rtl/azpr_bus_arbiter.sv
// Four-master non-preemptive bus arbiter for the AZPR shared bus.
// Handover policy set in bus_arb_next_owner (BUS_ARBITER_FIXED_PRIO_EN).
module azpr_bus_arbiter
   import azpr_bus_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic m0_req_n,
   output logic m0_grnt_n,
   input  logic m1_req_n,
   output logic m1_grnt_n,
   input  logic m2_req_n,
   output logic m2_grnt_n,
   input  logic m3_req_n,
   output logic m3_grnt_n
);

   logic [BUS_OWNER_BUS-1:0] owner_q;
   logic [BUS_OWNER_BUS-1:0] owner_d;
   logic [3:0]               req_n;

   assign req_n = {m3_req_n, m2_req_n, m1_req_n, m0_req_n};

   bus_arb_next_owner u_next_owner (
      .owner_i      (owner_q),
      .req_n_i      (req_n),
      .next_owner_o (owner_d)
   );

   // Owner register; reset parks the bus on master 0.
   always_ff @(posedge clk) begin
      if (reset == RESET_ENABLE) begin
         owner_q <= BUS_OWNER_MASTER_0;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Grants are a one-hot active-low decode of the owner.
   always_comb begin
      m0_grnt_n = (owner_q == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
      m1_grnt_n = (owner_q == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
      m2_grnt_n = (owner_q == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
      m3_grnt_n = (owner_q == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;
   end

endmodule

// File: tb/tb_azpr_bus_arbiter.sv
// Scoreboard bench for azpr_bus_arbiter.
// Directed test-plan scenarios followed by random request traffic.
module tb_azpr_bus_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic m0_req_n = 1'b1, m1_req_n = 1'b1;
   logic m2_req_n = 1'b1, m3_req_n = 1'b1;
   logic m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;
   int model_owner = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   azpr_bus_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req_n  (m0_req_n),
      .m0_grnt_n (m0_grnt_n),
      .m1_req_n  (m1_req_n),
      .m1_grnt_n (m1_grnt_n),
      .m2_req_n  (m2_req_n),
      .m2_grnt_n (m2_grnt_n),
      .m3_req_n  (m3_req_n),
      .m3_grnt_n (m3_grnt_n)
   );

   // Reference: owner keeps bus while requesting; else closest
   // requester in round-robin distance (or lowest index); else park.
   function automatic int ref_next(int cur, logic [3:0] rn);
      int best;
      int bd;
      int d;
      if (rn[cur] == 1'b0) return cur;
      best = cur;
      bd = 99;
      for (int j = 0; j < 4; j++) begin
         if (rn[j] == 1'b0) begin
`ifdef BUS_ARBITER_FIXED_PRIO_EN
            d = j;
`else
            d = (j - cur + 4) % 4;
`endif
            if (d < bd) begin
               bd = d;
               best = j;
            end
         end
      end
      return best;
   endfunction

   task automatic step(input logic rst, input logic [3:0] rn);
      logic [3:0] e;
      @(negedge clk);
      reset = rst;
      {m3_req_n, m2_req_n, m1_req_n, m0_req_n} = rn;
      if (rst) model_owner = 0;
      else model_owner = ref_next(model_owner, rn);
      e = 4'b1111;
      e[model_owner] = 1'b0;
      exp_q.push_back(e);
      started = 1'b1;
   endtask

   // Monitor: one-hot check every cycle, scoreboard pop after each edge.
   always @(posedge clk) begin
      logic [3:0] gv;
      logic [3:0] e;
      #1;
      if (started) begin
         gv = {m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n};
         checks++;
         if ($countones(~gv) != 1) begin
            errors++;
            $display("FAIL onehot got=%b want exactly one low", gv);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (gv !== e) begin
               errors++;
               $display("FAIL grant t=%0t got=%b want=%b", $time, gv, e);
            end
         end
      end
   end

   initial begin
      int waited;
      logic [3:0] rn;
      // Reset with m3 requesting, release, re-assert.
      step(1'b1, 4'b0111);
      step(1'b1, 4'b0111);
      step(1'b0, 4'b0111);
      step(1'b0, 4'b0111);
      step(1'b1, 4'b0111);
      // Non-preemption then handover m0 -> m1.
      step(1'b0, 4'b1110);
      step(1'b0, 4'b1100);
      step(1'b0, 4'b1100);
      step(1'b0, 4'b1101);
      // Owner m1, m3 and m2 request; m1 drops, then m2 drops.
      step(1'b0, 4'b0001);
      step(1'b0, 4'b0001);
      step(1'b0, 4'b0011);
      step(1'b0, 4'b0111);
      // Parking on m3.
      step(1'b0, 4'b1111);
      step(1'b0, 4'b1111);
      step(1'b0, 4'b1111);
      // Wrap: owner m3, m0 and m2 requesting, m3 releases.
      step(1'b0, 4'b0111);
      step(1'b0, 4'b0010);
      step(1'b0, 4'b1010);
      step(1'b0, 4'b1111);
      // Owner m2 via reset and hand-offs, then m1/m3 request.
      step(1'b1, 4'b1111);
      step(1'b0, 4'b1011);
      step(1'b0, 4'b0001);
      step(1'b0, 4'b0101);
      step(1'b0, 4'b0101);
      // Random traffic with occasional reset.
      rn = 4'b1111;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) rn = 4'($urandom);
         else rn[$urandom_range(0, 3)] = 1'($urandom);
         step($urandom_range(0, 29) == 0, rn);
      end
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
